// File: rtl/hist_accum.sv
// HOG cell histogram accumulator: each pixel's weight is split across two adjacent
// orientation bins through one shared FP adder; finished cells stream out bin by bin.

module hist_accum_fpu #(
  parameter int LAT = 5   // operand-to-result cycles, must be >= 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic [2:0]  fpuOp,
  input  logic [1:0]  rmode,
  output logic [31:0] out,
  output logic        done
);
  localparam int STAGES = LAT - 2;

  logic [31:0]       opbEff, big, sml, res;
  logic [23:0]       mBig, mSml;
  logic [7:0]        eBig, eSml, dExp;
  logic [26:0]       mx, myFull, myA, n;
  logic [27:0]       sum;
  logic [24:0]       mr;
  logic [4:0]        lz;
  logic signed [9:0] e;
  logic              sgn, effSub, g, rb, st, up, found;

  always_comb begin
    opbEff = {opb[31] ^ (fpuOp == 3'b001), opb[30:0]};
    if (opa[30:0] >= opbEff[30:0]) begin
      big = opa;    sml = opbEff;
    end else begin
      big = opbEff; sml = opa;
    end
    eBig   = big[30:23];
    eSml   = sml[30:23];
    // denormal inputs are flushed to zero
    mBig   = (eBig != 8'd0) ? {1'b1, big[22:0]} : 24'd0;
    mSml   = (eSml != 8'd0) ? {1'b1, sml[22:0]} : 24'd0;
    sgn    = big[31];
    effSub = big[31] ^ sml[31];
    dExp   = eBig - eSml;
    mx     = {mBig, 3'b000};
    myFull = {mSml, 3'b000};
    if (dExp >= 8'd27) myA = {26'd0, |mSml};
    else myA = (myFull >> dExp) | {26'd0, |(myFull & ((27'd1 << dExp) - 27'd1))};
    sum = effSub ? ({1'b0, mx} - {1'b0, myA}) : ({1'b0, mx} + {1'b0, myA});

    e     = $signed({2'b00, eBig});
    lz    = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else        lz = lz + 5'd1;
      end
    end
    if (sum[27]) begin
      n = {sum[27:2], sum[1] | sum[0]};
      e = e + 10'sd1;
    end else begin
      n = sum[26:0] << lz;
      e = e - $signed({5'd0, lz});
    end

    g  = n[2];
    rb = n[1];
    st = n[0];
    case (rmode)
      2'b00:   up = g & (rb | st | n[3]);
      2'b01:   up = 1'b0;
      2'b10:   up = (g | rb | st) & ~sgn;
      default: up = (g | rb | st) & sgn;
    endcase
    mr = {1'b0, n[26:3]} + {24'd0, up};
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'sd1;
    end
    res = {sgn, e[7:0], mr[22:0]};

    if (eBig == 8'hFF) begin
      if (big[22:0] != 23'd0 || (eSml == 8'hFF && effSub)) res = 32'h7FC0_0000;
      else res = {sgn, 8'hFF, 23'd0};
    end else if (mBig == 24'd0) res = {big[31] & sml[31], 31'd0};
    else if (sum == 28'd0)      res = {rmode == 2'b11, 31'd0};
    else if (e >= 10'sd255)     res = {sgn, 8'hFF, 23'd0};
    else if (e <= 10'sd0)       res = {sgn, 31'd0};
  end

  logic [STAGES:0]       vldPipe;
  logic [STAGES:0][31:0] resPipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vldPipe <= '0;
      resPipe <= '0;
    end else begin
      vldPipe[0] <= start;
      resPipe[0] <= res;
      for (int i = 1; i <= STAGES; i++) begin
        vldPipe[i] <= vldPipe[i-1];
        resPipe[i] <= resPipe[i-1];
      end
    end
  end

  assign done = vldPipe[STAGES];
  assign out  = resPipe[STAGES];
endmodule

module hist_accum #(
  parameter int NUM_BINS    = 9,
  parameter int CELL_PIXELS = 64,
  parameter int FPU_LAT     = 5
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iValid,
  output logic        oReady,
  input  logic [3:0]  iBinIdx,
  input  logic [31:0] iLeftBin,
  input  logic [31:0] iRightBin,
  output logic        oHistValid,
  input  logic        iHistReady,
  output logic [3:0]  oHistBin,
  output logic [31:0] oHistData,
  output logic        oErr
);
  typedef enum logic [1:0] {IDLE, ADD_L, ADD_R, DUMP} stateT;

  stateT                      state, nextState;
  logic [NUM_BINS-1:0][31:0]  acc;
  logic [3:0]                 idx, nextIdx, binSel, dumpK;
  logic [31:0]                wL, wR, fpuA, fpuB, fpuRes;
  logic [6:0]                 pixCnt;
  logic                       accept, illegal, issued, fpuStart, fpuDone;

  assign accept  = iValid && (state == IDLE);
  assign illegal = iBinIdx >= 4'(NUM_BINS);
  assign nextIdx = (idx == 4'(NUM_BINS - 1)) ? 4'd0 : idx + 4'd1;
  assign binSel  = (state == ADD_R) ? nextIdx : idx;
  assign fpuA    = acc[binSel];
  assign fpuB    = (state == ADD_R) ? wR : wL;

  hist_accum_fpu #(.LAT(FPU_LAT)) uFpu (
    .clk   (iClk),
    .rst_n (iRst_n),
    .start (fpuStart),
    .opa   (fpuA),
    .opb   (fpuB),
    .fpuOp (3'b000),
    .rmode (2'b00),
    .out   (fpuRes),
    .done  (fpuDone)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState  = state;
    oReady     = 1'b0;
    oHistValid = 1'b0;
    oHistBin   = 4'd0;
    oHistData  = 32'd0;
    fpuStart   = 1'b0;
    case (state)
      IDLE: begin
        oReady = 1'b1;
        if (accept) begin
          if (!illegal)                                nextState = ADD_L;
          else if (pixCnt + 7'd1 == 7'(CELL_PIXELS))   nextState = DUMP;
        end
      end
      ADD_L: begin
        fpuStart = !issued;
        if (fpuDone) nextState = ADD_R;
      end
      ADD_R: begin
        fpuStart = !issued;
        if (fpuDone) nextState = (pixCnt == 7'(CELL_PIXELS)) ? DUMP : IDLE;
      end
      DUMP: begin
        oHistValid = 1'b1;
        oHistBin   = dumpK;
        oHistData  = acc[dumpK];
        if (iHistReady && dumpK == 4'(NUM_BINS - 1)) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      acc    <= '0;
      pixCnt <= 7'd0;
      idx    <= 4'd0;
      wL     <= 32'd0;
      wR     <= 32'd0;
      issued <= 1'b0;
      dumpK  <= 4'd0;
      oErr   <= 1'b0;
    end else begin
      oErr <= accept && illegal;
      if (accept) begin
        pixCnt <= pixCnt + 7'd1;
        idx    <= iBinIdx;
        wL     <= iLeftBin;
        wR     <= iRightBin;
      end
      // operands stay put while the adder works; only the first cycle launches it
      if (fpuStart) issued <= 1'b1;
      if (fpuDone) begin
        issued      <= 1'b0;
        acc[binSel] <= fpuRes;
      end
      if (state == DUMP && iHistReady) begin
        if (dumpK == 4'(NUM_BINS - 1)) begin
          dumpK  <= 4'd0;
          acc    <= '0;
          pixCnt <= 7'd0;
        end else begin
          dumpK <= dumpK + 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_hist_accum.sv
// Scoreboarded bench for hist_accum: a real-valued bin model predicts each cell's dump.

module tb_hist_accum;
  localparam int NB  = 9;
  localparam int CP  = 64;
  localparam int LAT = 5;

  logic        iClk = 1'b0, iRst_n = 1'b1, iValid = 1'b0, iHistReady = 1'b1;
  logic [3:0]  iBinIdx = 4'd0;
  logic [31:0] iLeftBin = 32'd0, iRightBin = 32'd0;
  logic        oReady, oHistValid, oErr;
  logic [3:0]  oHistBin;
  logic [31:0] oHistData;

  int          checks = 0, errors = 0;
  int          pix = 0;
  real         model [NB];
  logic [35:0] sbq [$];

  always #5 iClk = ~iClk;

  hist_accum #(.NUM_BINS(NB), .CELL_PIXELS(CP), .FPU_LAT(LAT)) dut (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .iValid     (iValid),
    .oReady     (oReady),
    .iBinIdx    (iBinIdx),
    .iLeftBin   (iLeftBin),
    .iRightBin  (iRightBin),
    .oHistValid (oHistValid),
    .iHistReady (iHistReady),
    .oHistBin   (oHistBin),
    .oHistData  (oHistData),
    .oErr       (oErr)
  );

  // exact conversion for the small, exactly representable values used here
  function automatic logic [31:0] toSgl(input real v);
    logic [63:0] d;
    int          ex;
    if (v == 0.0) return 32'h0;
    d  = $realtobits(v);
    ex = int'(d[62:52]) - 1023 + 127;
    return {d[63], ex[7:0], d[51:29]};
  endfunction

  always @(negedge iClk) begin
    logic [35:0] exp;
    if (iRst_n && oHistValid && iHistReady) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL dump_unexpected got bin=%0d data=%h, expected no output", oHistBin, oHistData);
      end else begin
        exp = sbq.pop_front();
        if ({oHistBin, oHistData} !== exp) begin
          errors++;
          $display("FAIL dump_word got bin=%0d data=%h, expected bin=%0d data=%h",
                   oHistBin, oHistData, exp[35:32], exp[31:0]);
        end
      end
    end
  end

  task automatic clearModel();
    foreach (model[k]) model[k] = 0.0;
    pix = 0;
  endtask

  task automatic sendSample(input logic [3:0] idx, input real l, input real r,
                            input bit measure, output int lowCyc);
    int n;
    n = 0;
    while (oReady !== 1'b1 && n < 300) begin @(posedge iClk); #1; n++; end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL ready_timeout got oReady=%b, expected 1", oReady);
    end
    iValid = 1'b1; iBinIdx = idx; iLeftBin = toSgl(l); iRightBin = toSgl(r);
    @(posedge iClk); #1;
    iValid = 1'b0;
    if (int'(idx) < NB) begin
      model[int'(idx)]          += l;
      model[(int'(idx) + 1) % NB] += r;
    end
    pix++;
    if (pix == CP) begin
      for (int k = 0; k < NB; k++) sbq.push_back({4'(k), toSgl(model[k])});
      clearModel();
    end
    lowCyc = 0;
    if (measure)
      while (oReady !== 1'b1 && lowCyc < 50) begin lowCyc++; @(posedge iClk); #1; end
  endtask

  task automatic waitDrain(output bit ok);
    int n;
    n = 0;
    while ((sbq.size() != 0 || oHistValid === 1'b1) && n < 400) begin @(posedge iClk); #1; n++; end
    ok = (sbq.size() == 0) && (oHistValid === 1'b0) && (oReady === 1'b1);
  endtask

  task automatic test_reset();
    #1 iRst_n = 1'b0;
    #2;
    checks += 5;
    if (oReady !== 1'b1)     begin errors++; $display("FAIL reset_ready got %b, expected 1", oReady); end
    if (oHistValid !== 1'b0) begin errors++; $display("FAIL reset_hvalid got %b, expected 0", oHistValid); end
    if (oHistBin !== 4'd0)   begin errors++; $display("FAIL reset_bin got %0d, expected 0", oHistBin); end
    if (oHistData !== 32'd0) begin errors++; $display("FAIL reset_data got %h, expected 0", oHistData); end
    if (oErr !== 1'b0)       begin errors++; $display("FAIL reset_err got %b, expected 0", oErr); end
    repeat (3) @(posedge iClk);
    @(negedge iClk) iRst_n = 1'b1;
    @(posedge iClk); #1;
    clearModel();
  endtask

  task automatic test_basic();
    int low; bit ok;
    sendSample(4'd2, 1.0, 2.0, 1'b0, low);
    for (int i = 0; i < CP - 1; i++) sendSample(4'd0, 0.0, 0.0, 1'b0, low);
    waitDrain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_drain got pending=%0d hvalid=%b, expected 0/0", sbq.size(), oHistValid); end
  endtask

  task automatic test_wrap();
    int low; bit ok;
    sendSample(4'd8, 0.5, 1.5, 1'b0, low);
    for (int i = 0; i < CP - 1; i++) sendSample(4'd4, 0.0, 0.0, 1'b0, low);
    waitDrain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_drain got pending=%0d hvalid=%b, expected 0/0", sbq.size(), oHistValid); end
  endtask

  task automatic test_latency();
    int low; bit ok;
    for (int i = 0; i < CP; i++) begin
      sendSample(4'd0, 1.0, 1.0, i < CP - 1, low);
      if (i < CP - 1) begin
        checks++;
        if (low !== 2 * LAT) begin
          errors++;
          $display("FAIL busy_cycles sample %0d got %0d, expected %0d", i, low, 2 * LAT);
        end
      end
    end
    waitDrain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL latency_drain got pending=%0d hvalid=%b, expected 0/0", sbq.size(), oHistValid); end
  endtask

  task automatic test_err();
    int low; bit ok;
    sendSample(4'd12, 1.0, 1.0, 1'b1, low);
    checks += 2;
    if (oErr !== 1'b1) begin errors++; $display("FAIL err_pulse got %b, expected 1", oErr); end
    if (low !== 0)     begin errors++; $display("FAIL err_busy got %0d busy cycles, expected 0", low); end
    @(posedge iClk); #1;
    checks++;
    if (oErr !== 1'b0) begin errors++; $display("FAIL err_width got %b, expected 0", oErr); end
    for (int i = 0; i < CP - 1; i++) sendSample(4'd3, 0.0, 0.0, 1'b0, low);
    waitDrain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL err_drain got pending=%0d hvalid=%b, expected 0/0", sbq.size(), oHistValid); end
    // illegal index as the last pixel of a cell must still close the cell
    for (int i = 0; i < CP - 1; i++) sendSample(4'd5, 0.25, 0.75, 1'b0, low);
    sendSample(4'd15, 2.0, 2.0, 1'b0, low);
    checks++;
    if (oErr !== 1'b1) begin errors++; $display("FAIL err_last_pulse got %b, expected 1", oErr); end
    waitDrain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL err_last_drain got pending=%0d hvalid=%b, expected 0/0", sbq.size(), oHistValid); end
  endtask

  task automatic test_stall();
    int low, n; bit ok;
    sendSample(4'd4, 1.5, 2.5, 1'b0, low);
    for (int i = 0; i < CP - 2; i++) sendSample(4'd1, 0.0, 0.0, 1'b0, low);
    iHistReady = 1'b0;
    sendSample(4'd1, 0.0, 0.0, 1'b0, low);
    n = 0;
    while (oHistValid !== 1'b1 && n < 50) begin @(posedge iClk); #1; n++; end
    iHistReady = 1'b1;
    while (oHistBin !== 4'd4 && n < 70) begin @(posedge iClk); #1; n++; end
    iHistReady = 1'b0;
    checks++;
    if (n >= 70) begin errors++; $display("FAIL stall_reach_bin4 got bin=%0d, expected 4", oHistBin); end
    for (int c = 0; c < 5; c++) begin
      @(negedge iClk);
      checks++;
      if (oHistValid !== 1'b1 || oHistBin !== 4'd4 || oHistData !== 32'h3FC0_0000) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got v=%b bin=%0d data=%h, expected v=1 bin=4 data=3fc00000",
                 c, oHistValid, oHistBin, oHistData);
      end
      @(posedge iClk); #1;
    end
    iHistReady = 1'b1;
    waitDrain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_drain got pending=%0d hvalid=%b, expected 0/0", sbq.size(), oHistValid); end
    sendSample(4'd7, 1.0, 1.0, 1'b0, low);
    for (int i = 0; i < CP - 1; i++) sendSample(4'd2, 0.0, 0.0, 1'b0, low);
    waitDrain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL next_cell_drain got pending=%0d hvalid=%b, expected 0/0", sbq.size(), oHistValid); end
  endtask

  task automatic test_reset_mid();
    int low; bit ok;
    for (int i = 0; i < 10; i++) sendSample(4'd1, 1.0, 1.0, 1'b0, low);
    sendSample(4'd6, 4.0, 4.0, 1'b0, low);
    repeat (LAT + 2) @(posedge iClk);
    #2;
    checks++;
    if (oReady !== 1'b0) begin errors++; $display("FAIL mid_busy got oReady=%b, expected 0", oReady); end
    iRst_n = 1'b0;
    #1;
    checks += 4;
    if (oReady !== 1'b1)     begin errors++; $display("FAIL mid_reset_ready got %b, expected 1", oReady); end
    if (oHistValid !== 1'b0) begin errors++; $display("FAIL mid_reset_hvalid got %b, expected 0", oHistValid); end
    if (oHistData !== 32'd0) begin errors++; $display("FAIL mid_reset_data got %h, expected 0", oHistData); end
    if (oErr !== 1'b0)       begin errors++; $display("FAIL mid_reset_err got %b, expected 0", oErr); end
    clearModel();
    @(negedge iClk) iRst_n = 1'b1;
    @(posedge iClk); #1;
    sendSample(4'd6, 2.0, 0.5, 1'b0, low);
    for (int i = 0; i < CP - 1; i++) sendSample(4'd3, 0.0, 0.0, 1'b0, low);
    waitDrain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_drain got pending=%0d hvalid=%b, expected 0/0", sbq.size(), oHistValid); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_latency();
    test_err();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
